// File: rtl/spram_arbiter.sv
// Two-port round-robin arbiter in front of a single-port RAM.
// Each port has a one-entry read-response slot with valid/ready backpressure.
module spram_arbiter #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 32,
    localparam int MASK_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  resetn,

    input  logic                  a_cmd_valid,
    output logic                  a_cmd_ready,
    input  logic                  a_cmd_wr,
    input  logic [ADDR_WIDTH-1:0] a_cmd_addr,
    input  logic [MASK_WIDTH-1:0] a_cmd_mask,
    input  logic [DATA_WIDTH-1:0] a_cmd_data,
    output logic                  a_rsp_valid,
    input  logic                  a_rsp_ready,
    output logic [DATA_WIDTH-1:0] a_rsp_data,

    input  logic                  b_cmd_valid,
    output logic                  b_cmd_ready,
    input  logic                  b_cmd_wr,
    input  logic [ADDR_WIDTH-1:0] b_cmd_addr,
    input  logic [MASK_WIDTH-1:0] b_cmd_mask,
    input  logic [DATA_WIDTH-1:0] b_cmd_data,
    output logic                  b_rsp_valid,
    input  logic                  b_rsp_ready,
    output logic [DATA_WIDTH-1:0] b_rsp_data,

    output logic                  ram_en,
    output logic                  ram_wr,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [MASK_WIDTH-1:0] ram_mask,
    output logic [DATA_WIDTH-1:0] ram_wrData,
    input  logic [DATA_WIDTH-1:0] ram_rdData
);

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

    port_e                 last_q, last_d;
    logic                  infl_a_q, infl_a_d;
    logic                  infl_b_q, infl_b_d;
    logic                  full_a_q, full_a_d;
    logic                  full_b_q, full_b_d;
    logic [DATA_WIDTH-1:0] slot_a_q, slot_a_d;
    logic [DATA_WIDTH-1:0] slot_b_q, slot_b_d;

    logic elig_a, elig_b;
    logic gnt_a, gnt_b;

    // A read needs a free slot (or one draining this cycle) and no read
    // already outstanding; writes never produce a response, so never wait.
    always_comb begin
        elig_a = 1'b0;
        elig_b = 1'b0;
        if (resetn) begin
            elig_a = a_cmd_valid &
                     (a_cmd_wr | (~infl_a_q & (~full_a_q | a_rsp_ready)));
            elig_b = b_cmd_valid &
                     (b_cmd_wr | (~infl_b_q & (~full_b_q | b_rsp_ready)));
        end
    end

    always_comb begin
        gnt_a  = 1'b0;
        gnt_b  = 1'b0;
        last_d = last_q;
        if (elig_a && elig_b) begin
            if (last_q == PORT_B) begin
                gnt_a = 1'b1;
            end else begin
                gnt_b = 1'b1;
            end
        end else begin
            gnt_a = elig_a;
            gnt_b = elig_b;
        end
        if (gnt_a) begin
            last_d = PORT_A;
        end else if (gnt_b) begin
            last_d = PORT_B;
        end
    end

    assign a_cmd_ready = gnt_a;
    assign b_cmd_ready = gnt_b;

    always_comb begin
        ram_en     = 1'b0;
        ram_wr     = 1'b0;
        ram_addr   = '0;
        ram_mask   = '0;
        ram_wrData = '0;
        if (gnt_a) begin
            ram_en     = 1'b1;
            ram_wr     = a_cmd_wr;
            ram_addr   = a_cmd_addr;
            ram_mask   = a_cmd_mask;
            ram_wrData = a_cmd_data;
        end else if (gnt_b) begin
            ram_en     = 1'b1;
            ram_wr     = b_cmd_wr;
            ram_addr   = b_cmd_addr;
            ram_mask   = b_cmd_mask;
            ram_wrData = b_cmd_data;
        end
    end

    // Data returns the cycle after issue; an arriving load wins over a pop.
    always_comb begin
        infl_a_d = gnt_a & ~a_cmd_wr;
        infl_b_d = gnt_b & ~b_cmd_wr;

        full_a_d = full_a_q & ~a_rsp_ready;
        slot_a_d = slot_a_q;
        if (infl_a_q) begin
            full_a_d = 1'b1;
            slot_a_d = ram_rdData;
        end

        full_b_d = full_b_q & ~b_rsp_ready;
        slot_b_d = slot_b_q;
        if (infl_b_q) begin
            full_b_d = 1'b1;
            slot_b_d = ram_rdData;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_q   <= PORT_B;
            infl_a_q <= 1'b0;
            infl_b_q <= 1'b0;
            full_a_q <= 1'b0;
            full_b_q <= 1'b0;
            slot_a_q <= '0;
            slot_b_q <= '0;
        end else begin
            last_q   <= last_d;
            infl_a_q <= infl_a_d;
            infl_b_q <= infl_b_d;
            full_a_q <= full_a_d;
            full_b_q <= full_b_d;
            slot_a_q <= slot_a_d;
            slot_b_q <= slot_b_d;
        end
    end

    assign a_rsp_valid = full_a_q;
    assign a_rsp_data  = slot_a_q;
    assign b_rsp_valid = full_b_q;
    assign b_rsp_data  = slot_b_q;

endmodule

// File: tb/tb_spram_arbiter.sv
// Randomized bench for spram_arbiter against a queue-based reference model
// with a behavioural single-port RAM behind the arbiter.
module tb_spram_arbiter;

    localparam int AW = 14;
    localparam int DW = 32;
    localparam int MW = DW / 8;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic          a_cmd_valid, a_cmd_ready, a_cmd_wr;
    logic [AW-1:0] a_cmd_addr;
    logic [MW-1:0] a_cmd_mask;
    logic [DW-1:0] a_cmd_data;
    logic          a_rsp_valid, a_rsp_ready;
    logic [DW-1:0] a_rsp_data;
    logic          b_cmd_valid, b_cmd_ready, b_cmd_wr;
    logic [AW-1:0] b_cmd_addr;
    logic [MW-1:0] b_cmd_mask;
    logic [DW-1:0] b_cmd_data;
    logic          b_rsp_valid, b_rsp_ready;
    logic [DW-1:0] b_rsp_data;
    logic          ram_en, ram_wr;
    logic [AW-1:0] ram_addr;
    logic [MW-1:0] ram_mask;
    logic [DW-1:0] ram_wrData;
    logic [DW-1:0] ram_rdData = '0;

    spram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .resetn(resetn),
        .a_cmd_valid(a_cmd_valid), .a_cmd_ready(a_cmd_ready),
        .a_cmd_wr(a_cmd_wr), .a_cmd_addr(a_cmd_addr),
        .a_cmd_mask(a_cmd_mask), .a_cmd_data(a_cmd_data),
        .a_rsp_valid(a_rsp_valid), .a_rsp_ready(a_rsp_ready),
        .a_rsp_data(a_rsp_data),
        .b_cmd_valid(b_cmd_valid), .b_cmd_ready(b_cmd_ready),
        .b_cmd_wr(b_cmd_wr), .b_cmd_addr(b_cmd_addr),
        .b_cmd_mask(b_cmd_mask), .b_cmd_data(b_cmd_data),
        .b_rsp_valid(b_rsp_valid), .b_rsp_ready(b_rsp_ready),
        .b_rsp_data(b_rsp_data),
        .ram_en(ram_en), .ram_wr(ram_wr), .ram_addr(ram_addr),
        .ram_mask(ram_mask), .ram_wrData(ram_wrData),
        .ram_rdData(ram_rdData)
    );

    // Behavioural RAM: byte-masked write, registered read
    bit [DW-1:0] mem [256];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_wr) begin
                for (int i = 0; i < MW; i++)
                    if (ram_mask[i]) mem[ram_addr[7:0]][i*8 +: 8] <= ram_wrData[i*8 +: 8];
            end else begin
                ram_rdData <= mem[ram_addr[7:0]];
            end
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model
    typedef struct {
        int          due;
        logic [DW-1:0] d;
    } rsp_t;

    rsp_t        qa[$];
    rsp_t        qb[$];
    bit [DW-1:0] refm [256];
    int          cyc;
    int          last_rd [2];
    int          lg;

    // Stimulus for the current cycle, index 0 = a, 1 = b
    bit          v [2];
    bit          wr [2];
    bit          rr [2];
    logic [AW-1:0] ad [2];
    logic [MW-1:0] mk [2];
    logic [DW-1:0] wd [2];

    task automatic model_reset();
        qa.delete();
        qb.delete();
        last_rd[0] = -10;
        last_rd[1] = -10;
        lg = 1;
    endtask

    task automatic idle();
        for (int p = 0; p < 2; p++) begin
            v[p] = 0; wr[p] = 0; rr[p] = 0;
            ad[p] = '0; mk[p] = '0; wd[p] = '0;
        end
    endtask

    task automatic drive();
        a_cmd_valid = v[0]; a_cmd_wr = wr[0]; a_cmd_addr = ad[0];
        a_cmd_mask = mk[0]; a_cmd_data = wd[0]; a_rsp_ready = rr[0];
        b_cmd_valid = v[1]; b_cmd_wr = wr[1]; b_cmd_addr = ad[1];
        b_cmd_mask = mk[1]; b_cmd_data = wd[1]; b_rsp_ready = rr[1];
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step();
        bit vis [2];
        bit el [2];
        int g;
        drive();
        #1;
        vis[0] = (qa.size() > 0) && (qa[0].due <= cyc);
        vis[1] = (qb.size() > 0) && (qb[0].due <= cyc);
        for (int p = 0; p < 2; p++)
            el[p] = v[p] && (wr[p] || (last_rd[p] != cyc - 1 && (!vis[p] || rr[p])));
        if (el[0] && el[1]) g = (lg == 1) ? 0 : 1;
        else if (el[0]) g = 0;
        else if (el[1]) g = 1;
        else g = -1;

        check("a_cmd_ready", a_cmd_ready, g == 0);
        check("b_cmd_ready", b_cmd_ready, g == 1);
        check("ram_en", ram_en, g >= 0);
        if (g >= 0) begin
            check("ram_wr", ram_wr, wr[g]);
            check("ram_addr", ram_addr, ad[g]);
            check("ram_mask", ram_mask, mk[g]);
            check("ram_wrData", ram_wrData, wd[g]);
        end else begin
            check("ram_wr_idle", ram_wr, 0);
        end
        check("a_rsp_valid", a_rsp_valid, vis[0]);
        if (vis[0]) check("a_rsp_data", a_rsp_data, qa[0].d);
        check("b_rsp_valid", b_rsp_valid, vis[1]);
        if (vis[1]) check("b_rsp_data", b_rsp_data, qb[0].d);

        if (vis[0] && rr[0]) void'(qa.pop_front());
        if (vis[1] && rr[1]) void'(qb.pop_front());
        if (g >= 0) begin
            lg = g;
            if (wr[g]) begin
                for (int i = 0; i < MW; i++)
                    if (mk[g][i]) refm[ad[g][7:0]][i*8 +: 8] = wd[g][i*8 +: 8];
            end else begin
                rsp_t r;
                r.due = cyc + 2;
                r.d = refm[ad[g][7:0]];
                if (g == 0) qa.push_back(r);
                else qb.push_back(r);
                last_rd[g] = cyc;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic rnd(input int pv, input int pw, input int pr);
        for (int p = 0; p < 2; p++) begin
            v[p]  = ($urandom_range(99) < pv);
            wr[p] = ($urandom_range(99) < pw);
            rr[p] = ($urandom_range(99) < pr);
            ad[p] = AW'($urandom_range(15));
            if ($urandom_range(9) == 0) ad[p] = AW'($urandom_range(255));
            mk[p] = MW'($urandom);
            wd[p] = $urandom;
        end
    endtask

    initial begin
        cyc = 0;
        model_reset();
        idle();
        v[0] = 1; v[1] = 1; wr[0] = 1; wr[1] = 1; mk[0] = '1; mk[1] = '1;
        drive();
        @(negedge clk);
        #1;
        check("rst_a_cmd_ready", a_cmd_ready, 0);
        check("rst_b_cmd_ready", b_cmd_ready, 0);
        check("rst_ram_en", ram_en, 0);
        check("rst_ram_wr", ram_wr, 0);
        check("rst_a_rsp_valid", a_rsp_valid, 0);
        check("rst_b_rsp_valid", b_rsp_valid, 0);
        idle();
        drive();
        @(negedge clk);
        resetn = 1;

        // Single read of a known word
        idle(); v[0] = 1; wr[0] = 1; ad[0] = 14'h0010; mk[0] = '1; wd[0] = 32'hDEADBEEF;
        step();
        idle(); v[0] = 1; ad[0] = 14'h0010; rr[0] = 1;
        step();
        idle(); rr[0] = 1;
        repeat (3) step();

        // Contention: both write every cycle
        for (int k = 0; k < 4; k++) begin
            idle();
            for (int p = 0; p < 2; p++) begin
                v[p] = 1; wr[p] = 1; ad[p] = AW'(p + 2);
                mk[p] = (p == 0) ? 4'h3 : 4'hC; wd[p] = $urandom;
            end
            step();
        end

        // Backpressure then pop-and-load on b
        idle(); v[1] = 1; ad[1] = 14'h0003;
        step();
        for (int k = 0; k < 6; k++) begin
            idle(); v[1] = 1; ad[1] = 14'h0002;
            step();
        end
        idle(); v[1] = 1; ad[1] = 14'h0002; rr[1] = 1;
        step();
        idle(); rr[1] = 1;
        repeat (4) step();

        // Write during read on a
        idle(); v[0] = 1; ad[0] = 14'h0002;
        step();
        idle(); v[0] = 1; wr[0] = 1; ad[0] = 14'h0002; mk[0] = '1; wd[0] = 32'h12345678; rr[0] = 1;
        step();
        idle(); rr[0] = 1;
        repeat (3) step();

        // Random phases with varying load and backpressure
        for (int ph = 0; ph < 4; ph++) begin
            for (int k = 0; k < 500; k++) begin
                case (ph)
                    0: rnd(60, 30, 70);
                    1: rnd(95, 10, 25);
                    2: rnd(90, 50, 95);
                    default: rnd(40, 20, 50);
                endcase
                step();
            end
        end

        // Reset abort of an in-flight a read
        idle(); rr[0] = 1;
        repeat (3) step();
        idle(); v[0] = 1; ad[0] = 14'h0010;
        step();
        resetn = 0;
        idle(); rr[0] = 0; v[0] = 1; v[1] = 1; wr[0] = 1; wr[1] = 1;
        drive();
        #1;
        check("abort_a_rsp_valid", a_rsp_valid, 0);
        check("abort_ram_en", ram_en, 0);
        check("abort_a_cmd_ready", a_cmd_ready, 0);
        @(negedge clk);
        idle();
        drive();
        @(negedge clk);
        resetn = 1;
        model_reset();
        repeat (4) step();
        idle();
        for (int p = 0; p < 2; p++) begin
            v[p] = 1; wr[p] = 1; ad[p] = AW'(p + 8); mk[p] = '1; wd[p] = $urandom;
        end
        step();
        step();
        idle(); rr[0] = 1; rr[1] = 1;
        repeat (2) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
